// File: rtl/dm_port_arbiter_pkg.sv
// Shared types and constants for the data-SRAM port arbiter.
package dm_port_arbiter_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned LEN_W  = 4;

  localparam logic [DATA_W-1:0] BWEB_READ = 32'hFFFF_FFFF;
  localparam logic [DATA_W-1:0] BWEB_WORD = 32'h0000_0000;

  typedef enum logic {
    IDLE      = 1'b0,
    DMA_BURST = 1'b1
  } arb_state_e;

endpackage

// File: rtl/dm_port_arbiter_if.sv
// CPU, DMA and SRAM signal bundle; slave = arbiter side, master = environment side.
interface dm_port_arbiter_if #(
  parameter int unsigned ADDR_W = 14
);
  import dm_port_arbiter_pkg::*;

  logic              cpu_req;
  logic [DATA_W-1:0] cpu_bweb;
  logic [DATA_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_stall;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;

  logic              dma_req;
  logic              dma_we;
  logic [DATA_W-1:0] dma_addr;
  logic [LEN_W-1:0]  dma_len;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_wready;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_rvalid;
  logic              dma_busy;
  logic              dma_done;

  logic              dm_ceb;
  logic [DATA_W-1:0] dm_web;
  logic [ADDR_W-1:0] dm_a;
  logic [DATA_W-1:0] dm_di;
  logic [DATA_W-1:0] dm_do;

  modport slave (
    input  cpu_req, cpu_bweb, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rdata, cpu_rvalid,
    input  dma_req, dma_we, dma_addr, dma_len, dma_wdata,
    output dma_wready, dma_rdata, dma_rvalid, dma_busy, dma_done,
    output dm_ceb, dm_web, dm_a, dm_di,
    input  dm_do
  );

  modport master (
    output cpu_req, cpu_bweb, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rdata, cpu_rvalid,
    output dma_req, dma_we, dma_addr, dma_len, dma_wdata,
    input  dma_wready, dma_rdata, dma_rvalid, dma_busy, dma_done,
    input  dm_ceb, dm_web, dm_a, dm_di,
    output dm_do
  );

endinterface

// File: rtl/dm_burst_ctr.sv
// DMA burst word-address (wrapping) and remaining-beat counter.
module dm_burst_ctr
  import dm_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [LEN_W-1:0]  load_len,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q,  rem_d;

  // Load points at the beat after beat 0; each step consumes one beat.
  always_comb begin
    addr_d = addr_q;
    rem_d  = rem_q;
    if (load) begin
      addr_d = load_addr + ADDR_W'(1);
      rem_d  = load_len;
    end else if (step) begin
      addr_d = addr_q + ADDR_W'(1);
      rem_d  = rem_q - LEN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q <= '0;
      rem_q  <= '0;
    end else begin
      addr_q <= addr_d;
      rem_q  <= rem_d;
    end
  end

  assign addr = addr_q;
  assign last = (rem_q == LEN_W'(1));

endmodule

// File: rtl/dm_port_arbiter.sv
// Single-port data SRAM arbiter between CPU MEM stage and DMA burst engine.
// Optional DMA anti-starvation counter enabled by defining DM_ARB_STARVE_EN.
module dm_port_arbiter
  import dm_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = 14,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input logic               clk,
  input logic               reset,
  dm_port_arbiter_if.slave  bus
);

  arb_state_e        state_q, state_d;
  logic              we_q, we_d;
  logic              cpu_rv_q, cpu_rv_d;
  logic              dma_rv_q, dma_rv_d;
  logic              ctr_load, ctr_step, ctr_last;
  logic [ADDR_W-1:0] ctr_addr;
  logic [ADDR_W-1:0] dma_word;
  logic              dma_ok;
  logic              force_c;
  logic              cpu_grant, dma_beat, beat_we;

  assign dma_word = bus.dma_addr[ADDR_W+1:2];
  // A read burst's trailing data cycle still counts as busy, so new requests wait.
  assign dma_ok   = bus.dma_req & ~dma_rv_q;

  dm_burst_ctr #(.ADDR_W(ADDR_W)) u_ctr (
    .clk       (clk),
    .reset     (reset),
    .load      (ctr_load),
    .step      (ctr_step),
    .load_addr (dma_word),
    .load_len  (bus.dma_len),
    .addr      (ctr_addr),
    .last      (ctr_last)
  );

`ifdef DM_ARB_STARVE_EN
  localparam int unsigned STARVE_W = 32'($clog2(STARVE_LIMIT + 1));
  logic [STARVE_W-1:0] starve_q, starve_d;

  always_comb begin
    starve_d = starve_q;
    if (ctr_load) begin
      starve_d = '0;
    end else if (cpu_grant && dma_ok && (starve_q != STARVE_W'(STARVE_LIMIT))) begin
      starve_d = starve_q + STARVE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) starve_q <= '0;
    else        starve_q <= starve_d;
  end

  assign force_c = (starve_q == STARVE_W'(STARVE_LIMIT));
`else
  assign force_c = 1'b0;
`endif

  // Arbitration, next state and SRAM drive; everything is gated while in reset.
  always_comb begin
    state_d        = state_q;
    we_d           = we_q;
    ctr_load       = 1'b0;
    ctr_step       = 1'b0;
    cpu_grant      = 1'b0;
    dma_beat       = 1'b0;
    beat_we        = we_q;
    bus.dma_done   = 1'b0;
    bus.dm_ceb     = 1'b1;
    bus.dm_web     = BWEB_READ;
    bus.dm_a       = '0;
    bus.dm_di      = '0;
    if (reset) begin
      unique case (state_q)
        IDLE: begin
          if (bus.cpu_req && !(force_c && dma_ok)) begin
            cpu_grant = 1'b1;
          end else if (dma_ok) begin
            dma_beat = 1'b1;
            ctr_load = 1'b1;
            beat_we  = bus.dma_we;
            we_d     = bus.dma_we;
            if (bus.dma_len == LEN_W'(0)) bus.dma_done = 1'b1;
            else                          state_d      = DMA_BURST;
          end
        end
        DMA_BURST: begin
          dma_beat = 1'b1;
          ctr_step = 1'b1;
          if (ctr_last) begin
            bus.dma_done = 1'b1;
            state_d      = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (cpu_grant) begin
      bus.dm_ceb = 1'b0;
      bus.dm_web = bus.cpu_bweb;
      bus.dm_a   = bus.cpu_addr[ADDR_W+1:2];
      bus.dm_di  = bus.cpu_wdata;
    end else if (dma_beat) begin
      bus.dm_ceb = 1'b0;
      bus.dm_web = beat_we ? BWEB_WORD : BWEB_READ;
      bus.dm_a   = ctr_load ? dma_word : ctr_addr;
      bus.dm_di  = bus.dma_wdata;
    end
    cpu_rv_d       = cpu_grant && (bus.cpu_bweb == BWEB_READ);
    dma_rv_d       = dma_beat && !beat_we;
    bus.cpu_stall  = reset && bus.cpu_req && !cpu_grant;
    bus.dma_wready = dma_beat && beat_we;
    bus.dma_busy   = reset && ((state_q == DMA_BURST) || dma_rv_q || dma_beat);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      cpu_rv_q <= 1'b0;
      dma_rv_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      cpu_rv_q <= cpu_rv_d;
      dma_rv_q <= dma_rv_d;
    end
  end

  assign bus.cpu_rvalid = cpu_rv_q;
  assign bus.dma_rvalid = dma_rv_q;
  assign bus.cpu_rdata  = bus.dm_do;
  assign bus.dma_rdata  = bus.dm_do;

  logic unused_ok;
  assign unused_ok = ^{bus.cpu_addr[31:ADDR_W+2], bus.cpu_addr[1:0],
                       bus.dma_addr[31:ADDR_W+2], bus.dma_addr[1:0], 32'(STARVE_LIMIT)};

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Randomized self-checking bench for dm_port_arbiter against a burst-queue model.
module tb_dm_port_arbiter;
  import dm_port_arbiter_pkg::*;

  localparam int unsigned ADDR_W       = 14;
  localparam int unsigned STARVE_LIMIT = 8;
  localparam int unsigned AMASK        = (1 << ADDR_W) - 1;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dm_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  dm_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Model: words still owed by the active burst, plus read-data-pending flags.
  int unsigned beats_q[$];
  bit          m_we, m_cpu_rv, m_dma_rv, m_issued;
  int          m_starve;

  function automatic void chk32(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endfunction

  function automatic void chk1(string name, logic got, logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b t=%0t", name, got, exp, $time);
    end
  endfunction

  // Called right after inputs change at the falling edge.
  task automatic check_cycle();
    logic        e_ceb, e_stall, e_wr, e_busy, e_done;
    logic [31:0] e_web, e_di;
    int unsigned e_a, base;
    bit          cpu_g, dma_b, b_we, dma_ok, force_m;
    bus.dm_do = $urandom();
    #1;
    e_ceb = 1'b1; e_web = BWEB_READ; e_a = 0; e_di = '0; e_done = 1'b0;
    cpu_g = 1'b0; dma_b = 1'b0; b_we = 1'b0; m_issued = 1'b0; force_m = 1'b0;
    if (!reset) begin
      beats_q.delete();
      m_cpu_rv = 1'b0; m_dma_rv = 1'b0; m_starve = 0;
    end else if (beats_q.size() > 0) begin
      e_a    = beats_q.pop_front();
      dma_b  = 1'b1;
      b_we   = m_we;
      e_done = (beats_q.size() == 0);
    end else begin
      dma_ok = bus.dma_req && !m_dma_rv;
`ifdef DM_ARB_STARVE_EN
      force_m = (m_starve >= STARVE_LIMIT);
`endif
      if (bus.cpu_req && !(force_m && dma_ok)) begin
        cpu_g = 1'b1;
      end else if (dma_ok) begin
        dma_b    = 1'b1;
        b_we     = bus.dma_we;
        m_we     = bus.dma_we;
        base     = (bus.dma_addr >> 2) & AMASK;
        e_a      = base;
        for (int k = 1; k <= int'(bus.dma_len); k++) beats_q.push_back((base + k) & AMASK);
        e_done   = (bus.dma_len == 0);
        m_issued = 1'b1;
      end
      if (dma_b) m_starve = 0;
      else if (bus.cpu_req && dma_ok && m_starve < STARVE_LIMIT) m_starve++;
    end
    if (cpu_g) begin
      e_ceb = 1'b0; e_web = bus.cpu_bweb; e_a = (bus.cpu_addr >> 2) & AMASK; e_di = bus.cpu_wdata;
    end else if (dma_b) begin
      e_ceb = 1'b0; e_web = b_we ? BWEB_WORD : BWEB_READ; e_di = bus.dma_wdata;
    end
    e_stall = reset && bus.cpu_req && !cpu_g;
    e_wr    = dma_b && b_we;
    e_busy  = reset && (dma_b || m_dma_rv);
    chk1 ("dm_ceb",     bus.dm_ceb,     e_ceb);
    chk32("dm_web",     bus.dm_web,     e_web);
    chk32("dm_a",       32'(bus.dm_a),  e_a);
    chk32("dm_di",      bus.dm_di,      e_di);
    chk1 ("cpu_stall",  bus.cpu_stall,  e_stall);
    chk1 ("dma_wready", bus.dma_wready, e_wr);
    chk1 ("dma_busy",   bus.dma_busy,   e_busy);
    chk1 ("dma_done",   bus.dma_done,   e_done);
    chk1 ("cpu_rvalid", bus.cpu_rvalid, m_cpu_rv);
    chk1 ("dma_rvalid", bus.dma_rvalid, m_dma_rv);
    if (m_cpu_rv) chk32("cpu_rdata", bus.cpu_rdata, bus.dm_do);
    if (m_dma_rv) chk32("dma_rdata", bus.dma_rdata, bus.dm_do);
    m_cpu_rv = cpu_g && (bus.cpu_bweb == BWEB_READ);
    m_dma_rv = dma_b && !b_we;
  endtask

  task automatic idle_inputs();
    bus.cpu_req = 1'b0; bus.cpu_bweb = BWEB_READ; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = '0; bus.dma_len = '0;
    bus.dma_wdata = $urandom();
  endtask

  logic [13:0] wr_addrs [4];
  int          grant_cyc;
  bit          drop_req;
  int          cpu_pct;

  initial begin
    wr_addrs[0] = 14'h3FFE; wr_addrs[1] = 14'h3FFF; wr_addrs[2] = 14'h0000; wr_addrs[3] = 14'h0001;
    m_we = 1'b0; m_cpu_rv = 1'b0; m_dma_rv = 1'b0; m_starve = 0; m_issued = 1'b0;
    idle_inputs();
    bus.dm_do = '0;

    // Requests asserted during reset must not reach the SRAM.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.cpu_req = 1'b1; bus.dma_req = 1'b1; bus.dma_we = 1'b1;
      check_cycle();
    end
    chk1("rst_ceb", bus.dm_ceb, 1'b1);
    chk1("rst_stall", bus.cpu_stall, 1'b0);
    chk1("rst_busy", bus.dma_busy, 1'b0);
    @(negedge clk); reset = 1'b1; idle_inputs(); check_cycle();

    // CPU read
    @(negedge clk); bus.cpu_req = 1'b1; bus.cpu_addr = 32'h10; check_cycle();
    chk32("lit_rd_a", 32'(bus.dm_a), 32'd4);
    chk1 ("lit_rd_ceb", bus.dm_ceb, 1'b0);
    @(negedge clk); idle_inputs(); check_cycle();
    chk1 ("lit_rd_rvalid", bus.cpu_rvalid, 1'b1);

    // CPU byte store, lane 1
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_bweb = 32'hFFFF_00FF; bus.cpu_wdata = 32'h0000_AB00; bus.cpu_addr = 32'h24;
    check_cycle();
    chk32("lit_sb_web", bus.dm_web, 32'hFFFF_00FF);
    chk32("lit_sb_di",  bus.dm_di,  32'h0000_AB00);
    chk1 ("lit_sb_stall", bus.cpu_stall, 1'b0);
    @(negedge clk); idle_inputs(); check_cycle();
    chk1 ("lit_sb_norv", bus.cpu_rvalid, 1'b0);

    // DMA write burst wrapping the word address
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      idle_inputs();
      if (i == 0) begin
        bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 32'hFFF8; bus.dma_len = 4'd3;
      end
      check_cycle();
      chk32("lit_wr_a", 32'(bus.dm_a), 32'(wr_addrs[i]));
      chk1 ("lit_wr_wready", bus.dma_wready, 1'b1);
      chk1 ("lit_wr_done", bus.dma_done, i == 3);
    end
    @(negedge clk); idle_inputs(); check_cycle();
    chk1("lit_wr_busy_end", bus.dma_busy, 1'b0);

    // DMA read burst with CPU arriving mid-burst
    @(negedge clk); idle_inputs();
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 32'h40; bus.dma_len = 4'd1;
    check_cycle();
    chk32("lit_rb_a0", 32'(bus.dm_a), 32'h10);
    @(negedge clk); idle_inputs(); bus.cpu_req = 1'b1; bus.cpu_addr = 32'h80; check_cycle();
    chk1("lit_rb_stall", bus.cpu_stall, 1'b1);
    chk1("lit_rb_done",  bus.dma_done,  1'b1);
    chk1("lit_rb_rv1",   bus.dma_rvalid, 1'b1);
    @(negedge clk); bus.dma_wdata = $urandom(); check_cycle();
    chk1 ("lit_rb_cpu_go", bus.cpu_stall, 1'b0);
    chk32("lit_rb_cpu_a",  32'(bus.dm_a), 32'h20);
    chk1 ("lit_rb_rv2",    bus.dma_rvalid, 1'b1);
    @(negedge clk); idle_inputs(); check_cycle();
    chk1 ("lit_rb_rv_end", bus.dma_rvalid, 1'b0);
    chk1 ("lit_rb_busy_end", bus.dma_busy, 1'b0);

    // Contention: CPU and DMA both held high
    grant_cyc = 0;
    for (int i = 1; i <= 20 && grant_cyc == 0; i++) begin
      @(negedge clk); idle_inputs();
      bus.cpu_req = 1'b1; bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 32'h300;
      check_cycle();
      if (m_issued) grant_cyc = i;
    end
`ifdef DM_ARB_STARVE_EN
    chk32("lit_starve_grant", 32'(grant_cyc), 32'd9);
`else
    chk32("lit_strict_prio", 32'(grant_cyc), 32'd0);
`endif
    drop_req = (grant_cyc != 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.cpu_req = 1'b0;
      if (drop_req) bus.dma_req = 1'b0;
      check_cycle();
      if (m_issued) drop_req = 1'b1;
    end

    // Reset in the middle of an 8-beat burst
    @(negedge clk); idle_inputs();
    bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 32'h100; bus.dma_len = 4'd7;
    check_cycle();
    @(negedge clk); idle_inputs(); check_cycle();
    @(negedge clk); reset = 1'b0; check_cycle();
    chk1("lit_abort_ceb", bus.dm_ceb, 1'b1);
    chk1("lit_abort_done", bus.dma_done, 1'b0);
    chk1("lit_abort_wready", bus.dma_wready, 1'b0);
    @(negedge clk); check_cycle();
    @(negedge clk); reset = 1'b1; check_cycle();
    chk1("lit_post_rst_idle", bus.dm_ceb, 1'b1);
    @(negedge clk);
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 32'h200; bus.dma_len = 4'd2;
    check_cycle();
    chk32("lit_restart_a", 32'(bus.dm_a), 32'h80);
    chk32("lit_restart_web", bus.dm_web, BWEB_READ);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); idle_inputs(); check_cycle();
    end

    // Random traffic
    drop_req = 1'b0;
    cpu_pct  = 50;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      if (cyc % 250 == 0) cpu_pct = (($urandom_range(0, 3) == 0) ? 100 : int'($urandom_range(10, 90)));
      reset = ($urandom_range(0, 399) != 0);
      bus.cpu_req   = ($urandom_range(0, 99) < cpu_pct);
      bus.cpu_addr  = $urandom();
      bus.cpu_wdata = $urandom();
      case ($urandom_range(0, 3))
        0:       bus.cpu_bweb = BWEB_READ;
        1:       bus.cpu_bweb = BWEB_WORD;
        2:       bus.cpu_bweb = ~(32'hFF << (8 * $urandom_range(0, 3)));
        default: bus.cpu_bweb = $urandom();
      endcase
      if (drop_req) begin
        bus.dma_req = 1'b0;
        drop_req    = 1'b0;
      end
      if (!bus.dma_req && $urandom_range(0, 7) == 0) begin
        bus.dma_req  = 1'b1;
        bus.dma_we   = 1'($urandom_range(0, 1));
        bus.dma_addr = ($urandom_range(0, 3) == 0) ? ($urandom() | 32'h0000_FFE0) : $urandom();
        bus.dma_len  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      end
      bus.dma_wdata = $urandom();
      check_cycle();
      if (m_issued) drop_req = 1'b1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dm_port_arbiter.md
# dm_port_arbiter

Arbitrates the single-port data SRAM between the CPU MEM stage and a DMA burst engine. It sits between the EX/MEM pipeline register outputs and the data SRAM macro. CPU store data and active-low bitwise write masks arrive already lane-aligned. The block sequences multi-word DMA bursts, stalls the pipeline when the CPU loses the port, and returns read data with the SRAM's one-cycle latency.

## Interface
- ADDR_W, 14: SRAM word-address width; word index = byte address [ADDR_W+1:2]
- STARVE_LIMIT, 8: consecutive denied DMA cycles before DMA is forced ahead (only with macro)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- cpu_req  in  1  MEM stage access this cycle (load or store)
- cpu_bweb  in  32  active-low bitwise write mask; all-ones = read
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  lane-aligned store data
- cpu_stall  out  1  CPU request not served this cycle; pipeline holds
- cpu_rdata  out  32  = dm_do; valid when cpu_rvalid
- cpu_rvalid  out  1  registered; high the cycle after a granted CPU read
- dma_req  in  1  burst request; held until first beat issues
- dma_we  in  1  1 = full-word write burst, 0 = read burst
- dma_addr  in  32  burst start byte address
- dma_len  in  4  beats minus one (1–16 words)
- dma_wdata  in  32  current write-beat data
- dma_wready  out  1  write beat consumed this cycle; DMA advances data
- dma_rdata  out  32  = dm_do; valid when dma_rvalid
- dma_rvalid  out  1  registered; high the cycle after each read beat
- dma_busy  out  1  burst in progress or read data pending
- dma_done  out  1  one-cycle pulse on the last beat's issue cycle
- dm_ceb  out  1  SRAM chip enable, active-low
- dm_web  out  32  SRAM bitwise write enable, active-low
- dm_a  out  ADDR_W  SRAM word address
- dm_di  out  32  SRAM write data
- dm_do  in  32  SRAM read data, valid one cycle after access

## Operation
- FSM states: IDLE, DMA_BURST.
- IDLE, cpu_req and not forced: CPU granted. SRAM driven combinationally from cpu_* this cycle. cpu_stall=0.
- IDLE, dma_req and (no cpu_req or forced): beat 0 issues this cycle.
  - Latch word address+1, remaining = dma_len, dma_we.
  - If dma_len==0: pulse dma_done and stay IDLE. Otherwise go to DMA_BURST.
- DMA_BURST: one beat per cycle. Address increments by one word, wrapping mod 2^ADDR_W. remaining decrements. When remaining==1, that beat pulses dma_done and the FSM returns to IDLE.
- DMA beats use dm_web all-zero (write) or all-ones (read). dm_di = dma_wdata. dma_wready = 1 on each write beat.
- Bursts are never preempted. cpu_stall = cpu_req during DMA_BURST and during the IDLE cycle DMA wins.
- dma_req is ignored while dma_busy.
- No requester: dm_ceb=1, dm_web=all-ones, dm_a/dm_di=0.

## Timing
- Grant is combinational within the request cycle. Read data arrives cycle+1 alongside the registered rvalid.
- dma_busy stays high until the final dma_rvalid for read bursts, and until the dma_done cycle for write bursts.
- Simultaneous dma_done and cpu_req: CPU is stalled that cycle and granted next cycle (IDLE).
- Reset (reset=0, any time): FSM goes to IDLE, counters are cleared, and the burst is aborted with no dma_done.
  - Outputs during reset: dm_ceb=1, dm_web=all-ones, cpu_stall=0, dma_wready=0, cpu_rvalid=dma_rvalid=0, dma_busy=0, dma_done=0.
  - The first access may issue in the first clock edge after reset deassertion.

## Configuration
- DM_ARB_STARVE_EN defined: a starve counter increments each IDLE cycle with cpu_req&dma_req and DMA denied.
  - When the counter reaches STARVE_LIMIT, DMA wins the next IDLE arbitration regardless of cpu_req.
  - The counter clears on any DMA grant and saturates at STARVE_LIMIT.
- DM_ARB_STARVE_EN undefined: CPU has strict priority, with no counter logic.

## Structure
- Shared package: state enum (IDLE, DMA_BURST), BWEB_READ=32'hFFFF_FFFF, BWEB_WORD=32'h0.
- Sub-module dm_burst_ctr holds the word-address increment/wrap and remaining-beat counter, with load/step/last outputs. The FSM and arbitration live in dm_port_arbiter.

## Test plan
- CPU read: cpu_req, bweb=all-ones, addr=0x10 → dm_a=4 and dm_ceb=0 same cycle; cpu_rvalid next cycle, with cpu_rdata=dm_do.
- CPU SB, lane 1: bweb=0xFFFF00FF, wdata=0x0000AB00 → dm_web/dm_di pass through unchanged; cpu_stall=0.
- DMA write burst: len=3, addr=0xFFF8, ADDR_W=14 → dm_a = 0x3FFE, 0x3FFF, 0x0000, 0x0001. Four dma_wready pulses; dma_done on the 4th beat.
- DMA read burst len=1 with cpu_req raised mid-burst → cpu_stall=1 until the burst ends. Two dma_rvalid pulses; CPU granted the cycle after dma_done.
- Starvation (macro on, STARVE_LIMIT=8): cpu_req and dma_req held high → DMA granted on the 9th cycle. Macro off: DMA never granted while cpu_req stays high.
- reset driven low mid-burst (beat 2 of 8) → dm_ceb=1, no dma_done. After release, a new dma_req starts cleanly at beat 0.
